// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, canonical NOP
// and the instruction fetch FSM state encoding.
package riscv_pkg;

    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JAL    = 7'h6f;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] AUIPC  = 7'h17;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory port: request handshake plus
// unconditional response strobe.
interface fetch_stage_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry {pc, instr} holding buffer for a fetched word
// that arrives while decode is stalled.
module fetch_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_instr,
    output logic        full,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full  <= 1'b1;
            pc    <= push_pc;
            instr <= push_instr;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem FSM,
// skid buffer and the IF/ID output register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master imem,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          if_valid,
    output logic [31:0]   if_pc,
    output logic [31:0]   if_instr,
    output logic [6:0]    opcode,
    output logic [2:0]    funct3,
    output logic [6:0]    funct7
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic [31:0]  redir_pc;
    logic         skid_full;
    logic [31:0]  skid_pc;
    logic [31:0]  skid_instr;
    logic         accept;
    logic         rsp_take;
    logic         slot_free;
    logic         load_rsp;
    logic         push;
    logic         pop;

    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

    // No new request while a word is parked in the skid
    assign imem.imem_req_valid = (state == REQ) && !skid_full;
    assign imem.imem_addr      = pc;

    assign accept    = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_take  = (state == WAIT) && imem.imem_rsp_valid
                       && !redirect_valid;
    assign slot_free = !if_valid || !stall;
    assign load_rsp  = rsp_take && slot_free && !skid_full;
    assign push      = rsp_take && !load_rsp;
    assign pop       = if_valid && !stall && skid_full
                       && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= REQ;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            unique case (state)
                REQ: begin
                    if (redirect_valid) begin
                        pc    <= redir_pc;
                        state <= accept ? DROP : REQ;
                    end else if (accept) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid)
                        pc <= redir_pc;
                    if (imem.imem_rsp_valid)
                        state <= REQ;
                    else if (redirect_valid)
                        state <= DROP;
                end
                DROP: begin
                    if (redirect_valid)
                        pc <= redir_pc;
                    if (imem.imem_rsp_valid)
                        state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
        end else if (load_rsp) begin
            if_valid <= 1'b1;
            if_pc    <= req_pc;
            if_instr <= imem.imem_rsp_data;
        end else if (pop) begin
            if_valid <= 1'b1;
            if_pc    <= skid_pc;
            if_instr <= skid_instr;
        end else if (if_valid && !stall) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
        end
    end

    fetch_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .pop        (pop),
        .push_pc    (req_pc),
        .push_instr (imem.imem_rsp_data),
        .full       (skid_full),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle imem model
// that can be switched to manual response control.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        mem_auto;
    logic        outstanding;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_stage_if m ();

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (m.master),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (a == 32'h0000_010C)
            return 32'h0050_0093;
        return {a[19:0], 12'h093};
    endfunction

    // A response with nothing outstanding is a protocol error
    always @(posedge clk) begin
        if (rst)
            outstanding <= 1'b0;
        else if (m.imem_rsp_valid)
            outstanding <= 1'b0;
        else if (m.imem_req_valid && m.imem_req_ready)
            outstanding <= 1'b1;
        if (!rst)
            assert (!(m.imem_rsp_valid && !outstanding))
                else $error("FAIL proto: rsp_valid=1 required no outstanding rsp");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic        acc;
        logic [31:0] a;
        acc = mem_auto && !rst && m.imem_req_valid && m.imem_req_ready;
        a   = m.imem_addr;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            m.imem_rsp_valid = acc;
            m.imem_rsp_data  = acc ? mem_word(a) : 32'h0;
        end
    endtask

    initial begin
        rst              = 1'b1;
        stall            = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        mem_auto         = 1'b1;
        m.imem_req_ready = 1'b1;
        m.imem_rsp_valid = 1'b0;
        m.imem_rsp_data  = '0;
        step();
        step();
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, NOP_INSTR);
        rst = 1'b0;
        chk("first_addr", m.imem_addr, 32'h100);
        chk("first_req", {31'b0, m.imem_req_valid}, 32'h1);

        // streaming, 1-cycle memory
        step();
        chk("wait_noreq", {31'b0, m.imem_req_valid}, 32'h0);
        step();
        chk("s0_valid", {31'b0, if_valid}, 32'h1);
        chk("s0_pc", if_pc, 32'h100);
        chk("s0_instr", if_instr, 32'h0010_0093);
        chk("s0_addr", m.imem_addr, 32'h104);
        step();
        step();
        chk("s1_pc", if_pc, 32'h104);
        chk("s1_instr", if_instr, 32'h0010_4093);
        chk("s1_opcode", {25'b0, opcode}, 32'h13);
        chk("s1_funct3", {29'b0, funct3}, 32'h4);
        chk("s1_funct7", {25'b0, funct7}, 32'h0);
        chk("s1_addr", m.imem_addr, 32'h108);

        // memory not ready for 3 cycles
        m.imem_req_ready = 1'b0;
        step();
        chk("nr_drain", {31'b0, if_valid}, 32'h0);
        chk("nr_addr0", m.imem_addr, 32'h108);
        step();
        chk("nr_addr1", m.imem_addr, 32'h108);
        step();
        chk("nr_addr2", m.imem_addr, 32'h108);
        chk("nr_req", {31'b0, m.imem_req_valid}, 32'h1);
        m.imem_req_ready = 1'b1;
        step();
        step();
        chk("nr_pc", if_pc, 32'h108);
        chk("nr_instr", if_instr, 32'h0010_8093);

        // response under stall lands in skid
        stall = 1'b1;
        step();
        chk("sk_hold_pc", if_pc, 32'h108);
        step();
        chk("sk_noreq", {31'b0, m.imem_req_valid}, 32'h0);
        chk("sk_hold_instr", if_instr, 32'h0010_8093);
        step();
        step();
        chk("sk_hold2", if_instr, 32'h0010_8093);
        chk("sk_noreq2", {31'b0, m.imem_req_valid}, 32'h0);
        stall = 1'b0;
        step();
        chk("sk_instr", if_instr, 32'h0050_0093);
        chk("sk_pc", if_pc, 32'h10C);
        chk("sk_valid", {31'b0, if_valid}, 32'h1);
        chk("sk_addr", m.imem_addr, 32'h110);

        // redirect while in WAIT, stale response dropped
        mem_auto = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        chk("rd_valid", {31'b0, if_valid}, 32'h0);
        chk("rd_noreq", {31'b0, m.imem_req_valid}, 32'h0);
        m.imem_rsp_valid = 1'b1;
        m.imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        m.imem_rsp_valid = 1'b0;
        chk("rd_drop_v", {31'b0, if_valid}, 32'h0);
        chk("rd_drop_i", if_instr, NOP_INSTR);
        chk("rd_addr", m.imem_addr, 32'h200);
        mem_auto = 1'b1;
        step();
        chk("rd_pend", {31'b0, if_valid}, 32'h0);
        step();
        chk("rd_pc", if_pc, 32'h200);
        chk("rd_instr", if_instr, 32'h0020_0093);

        // redirect coincident with a response
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step();
        redirect_valid = 1'b0;
        chk("rc_valid", {31'b0, if_valid}, 32'h0);
        chk("rc_addr", m.imem_addr, 32'h300);
        step();
        chk("rc_instr", if_instr, NOP_INSTR);
        step();
        chk("rc_pc", if_pc, 32'h300);
        chk("rc_new", if_instr, 32'h0030_0093);

        // reset while WAIT with stall held
        stall    = 1'b1;
        mem_auto = 1'b0;
        m.imem_rsp_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("mr_valid", {31'b0, if_valid}, 32'h0);
        chk("mr_instr", if_instr, NOP_INSTR);
        chk("mr_addr", m.imem_addr, 32'h100);
        chk("mr_pc", if_pc, 32'h0);
        rst   = 1'b0;
        stall = 1'b0;

        // redirect from REQ (no accept), then PC wrap
        m.imem_req_ready = 1'b0;
        redirect_valid   = 1'b1;
        redirect_pc      = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        chk("wr_addr", m.imem_addr, 32'hFFFF_FFFC);
        m.imem_req_ready = 1'b1;
        mem_auto = 1'b1;
        step();
        step();
        chk("wr_pc", if_pc, 32'hFFFF_FFFC);
        chk("wr_instr", if_instr, 32'hFFFF_C093);
        chk("wr_next", m.imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded limit");
        $fatal(1);
    end

endmodule
